// File: rtl/tv80_pkg.sv
// Shared encodings for the TV80 16-bit arithmetic sequencer: request ops,
// ALU_Op codes, flag bit positions and sequencer states.
package tv80_pkg;

   localparam logic [1:0] OP_ADD16    = 2'b00;
   localparam logic [1:0] OP_ADC16    = 2'b01;
   localparam logic [1:0] OP_SBC16    = 2'b10;
   localparam logic [1:0] OP_ADD_SP_E = 2'b11;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_ADC = 4'b0001;
   localparam logic [3:0] ALU_SBC = 4'b0011;
   localparam logic [3:0] ALU_NOP = 4'b1111;

   localparam int FLAG_C = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_P = 2;
   localparam int FLAG_X = 3;
   localparam int FLAG_H = 4;
   localparam int FLAG_Y = 5;
   localparam int FLAG_Z = 6;
   localparam int FLAG_S = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LO   = 2'b01,
      ST_HI   = 2'b10,
      ST_DONE = 2'b11
   } seq_state_t;

   // Low-byte pass: plain adds start without carry, ADC/SBC consume the issued carry
   function automatic logic [3:0] lo_alu_op(input logic [1:0] op);
      logic [3:0] r;
      case (op)
         OP_ADC16: r = ALU_ADC;
         OP_SBC16: r = ALU_SBC;
         default:  r = ALU_ADD;
      endcase
      return r;
   endfunction

   // High-byte pass always chains the carry/borrow out of the low pass
   function automatic logic [3:0] hi_alu_op(input logic [1:0] op);
      return (op == OP_SBC16) ? ALU_SBC : ALU_ADC;
   endfunction

endpackage

// File: rtl/tv80_alu16_seq.sv
// Runs 16-bit ADD/ADC/SBC HL,rr and GB ADD SP,e as two chained passes through
// the external 8-bit ALU (low byte first) behind a request/response handshake.
module tv80_alu16_seq
   import tv80_pkg::*;
#(
   parameter int Mode   = 3,
   parameter int Flag_C = FLAG_C,
   parameter int Flag_N = FLAG_N,
   parameter int Flag_P = FLAG_P,
   parameter int Flag_X = FLAG_X,
   parameter int Flag_H = FLAG_H,
   parameter int Flag_Y = FLAG_Y,
   parameter int Flag_Z = FLAG_Z,
   parameter int Flag_S = FLAG_S
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   input  logic [7:0]  req_f,
   output logic [3:0]  alu_op,
   output logic [7:0]  alu_busa,
   output logic [7:0]  alu_busb,
   output logic [7:0]  alu_f_in,
   output logic        alu_arith16,
   output logic        alu_z16,
   input  logic [7:0]  alu_q,
   input  logic [7:0]  alu_f_out,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_q,
   output logic [7:0]  rsp_f
);

   seq_state_t  state_q;
   logic [1:0]  op_q;
   logic [7:0]  a_hi_q;
   logic [7:0]  b_hi_q;
   logic [7:0]  q_lo_q;
   logic        f_lo_h_q;
   logic        f_lo_c_q;
   // ADD SP,e passes S/Y/X/P straight from the issue flags
   logic        keep_s_q;
   logic        keep_y_q;
   logic        keep_x_q;
   logic        keep_p_q;
   logic [1:0]  op_d;
   logic [7:0]  rsp_f_d;

   // Off the GB core there is no ADD SP,e; the encoding falls back to ADD16
   always_comb begin
      op_d = req_op;
      if (req_op == OP_ADD_SP_E && Mode != 3) begin
         op_d = OP_ADD16;
      end else begin
         op_d = req_op;
      end
   end

   // Final flag byte: ALU result, or the ADD SP,e merge of issue flags and low-pass H/C
   always_comb begin
      rsp_f_d = alu_f_out;
      if (op_q == OP_ADD_SP_E) begin
         rsp_f_d[Flag_S] = keep_s_q;
         rsp_f_d[Flag_Z] = 1'b0;
         rsp_f_d[Flag_Y] = keep_y_q;
         rsp_f_d[Flag_H] = f_lo_h_q;
         rsp_f_d[Flag_X] = keep_x_q;
         rsp_f_d[Flag_P] = keep_p_q;
         rsp_f_d[Flag_N] = 1'b0;
         rsp_f_d[Flag_C] = f_lo_c_q;
      end else begin
         rsp_f_d = alu_f_out;
      end
   end

   // Sequencer FSM; every ALU drive and response output is registered here
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_q       <= 16'h0000;
         rsp_f       <= 8'h00;
         alu_op      <= ALU_NOP;
         alu_busa    <= 8'h00;
         alu_busb    <= 8'h00;
         alu_f_in    <= 8'h00;
         alu_arith16 <= 1'b0;
         alu_z16     <= 1'b0;
         op_q        <= OP_ADD16;
         a_hi_q      <= 8'h00;
         b_hi_q      <= 8'h00;
         q_lo_q      <= 8'h00;
         f_lo_h_q    <= 1'b0;
         f_lo_c_q    <= 1'b0;
         keep_s_q    <= 1'b0;
         keep_y_q    <= 1'b0;
         keep_x_q    <= 1'b0;
         keep_p_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  state_q     <= ST_LO;
                  req_ready   <= 1'b0;
                  op_q        <= op_d;
                  a_hi_q      <= req_a[15:8];
                  b_hi_q      <= (op_d == OP_ADD_SP_E) ? {8{req_b[7]}} : req_b[15:8];
                  keep_s_q    <= req_f[Flag_S];
                  keep_y_q    <= req_f[Flag_Y];
                  keep_x_q    <= req_f[Flag_X];
                  keep_p_q    <= req_f[Flag_P];
                  alu_op      <= lo_alu_op(op_d);
                  alu_busa    <= req_a[7:0];
                  alu_busb    <= req_b[7:0];
                  alu_f_in    <= req_f;
                  alu_arith16 <= (op_d == OP_ADD16);
                  alu_z16     <= 1'b0;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_LO: begin
               state_q  <= ST_HI;
               q_lo_q   <= alu_q;
               f_lo_h_q <= alu_f_out[Flag_H];
               f_lo_c_q <= alu_f_out[Flag_C];
               alu_op   <= hi_alu_op(op_q);
               alu_busa <= a_hi_q;
               alu_busb <= b_hi_q;
               alu_f_in <= alu_f_out;
               // Z16 makes the high pass report Z = Z_lo & Z_hi
               alu_z16  <= (op_q == OP_ADC16) || (op_q == OP_SBC16);
            end
            ST_HI: begin
               state_q     <= ST_DONE;
               rsp_valid   <= 1'b1;
               rsp_q       <= {alu_q, q_lo_q};
               rsp_f       <= rsp_f_d;
               alu_op      <= ALU_NOP;
               alu_busa    <= 8'h00;
               alu_busb    <= 8'h00;
               alu_f_in    <= 8'h00;
               alu_arith16 <= 1'b0;
               alu_z16     <= 1'b0;
            end
            ST_DONE: begin
               if (rsp_ready) begin
                  state_q   <= ST_IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end else begin
                  state_q <= ST_DONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// Self-checking bench: bench-side 8-bit ALU feeds the sequencer, a 16-bit
// arithmetic reference model predicts every response and its timing.
module tb_tv80_alu16_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [15:0] req_a = 16'h0000;
   logic [15:0] req_b = 16'h0000;
   logic [7:0]  req_f = 8'h00;
   logic [3:0]  alu_op;
   logic [7:0]  alu_busa;
   logic [7:0]  alu_busb;
   logic [7:0]  alu_f_in;
   logic        alu_arith16;
   logic        alu_z16;
   logic [7:0]  alu_q;
   logic [7:0]  alu_f_out;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_q;
   logic [7:0]  rsp_f;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tv80_alu16_seq dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_f(req_f),
      .alu_op(alu_op), .alu_busa(alu_busa), .alu_busb(alu_busb), .alu_f_in(alu_f_in),
      .alu_arith16(alu_arith16), .alu_z16(alu_z16), .alu_q(alu_q), .alu_f_out(alu_f_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_f(rsp_f)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // 8-bit ALU (add/adc/sbc subset, 1111 passes flags through)
   function automatic logic [15:0] alu8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] fin, input logic ar16, input logic z16);
      logic sub, cin;
      logic [7:0] bb, q, f;
      int s, h, l7;
      f = fin; q = a; sub = 1'b0; cin = 1'b0; bb = b;
      if (op[3:2] == 2'b00) begin
         sub = op[1];
         cin = sub ^ (op[0] & fin[0]);
         bb  = sub ? ~b : b;
         s   = int'(a) + int'(bb) + int'(cin);
         h   = int'(a[3:0]) + int'(bb[3:0]) + int'(cin);
         l7  = int'(a[6:0]) + int'(bb[6:0]) + int'(cin);
         q   = 8'(s);
         f[0] = sub ^ (s >= 256);
         f[1] = sub;
         f[2] = (l7 >= 128) ^ (s >= 256);
         f[4] = sub ^ (h >= 16);
         f[3] = q[3];
         f[5] = q[5];
         f[7] = q[7];
         f[6] = (q == 8'h00) ? (z16 ? fin[6] : 1'b1) : 1'b0;
         if (ar16) begin
            f[7] = fin[7]; f[6] = fin[6]; f[2] = fin[2];
         end
      end
      return {q, f};
   endfunction

   always_comb begin
      {alu_q, alu_f_out} = alu8(alu_op, alu_busa, alu_busb, alu_f_in, alu_arith16, alu_z16);
   end

   // 16-bit reference: whole-word arithmetic, flags from Z80/GB rules; returns {q, f}
   function automatic logic [23:0] ref16(input logic [1:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [7:0] f);
      int ai, bi, ci, r;
      logic [15:0] q;
      logic [7:0] o;
      logic h, v, c;
      ai = int'(a); bi = int'(b); ci = int'(f[0]);
      o = f; q = 16'h0000;
      case (op)
         2'b00: begin
            r = ai + bi; q = 16'(r);
            o[0] = (r >= 65536); o[1] = 1'b0;
            o[4] = ((ai % 4096) + (bi % 4096)) >= 4096;
            o[3] = q[11]; o[5] = q[13];
         end
         2'b01: begin
            r = ai + bi + ci; q = 16'(r);
            c = (r >= 65536);
            h = ((ai % 4096) + (bi % 4096) + ci) >= 4096;
            v = (a[15] == b[15]) && (q[15] != a[15]);
            o = {q[15], (q == 16'h0000), q[13], h, q[11], v, 1'b0, c};
         end
         2'b10: begin
            r = ai - bi - ci; q = 16'(r);
            c = (ai < bi + ci);
            h = (ai % 4096) < ((bi % 4096) + ci);
            v = (a[15] != b[15]) && (q[15] != a[15]);
            o = {q[15], (q == 16'h0000), q[13], h, q[11], v, 1'b1, c};
         end
         default: begin
            r = ai + int'({{8{b[7]}}, b[7:0]}); q = 16'(r);
            o[6] = 1'b0; o[1] = 1'b0;
            o[4] = ((ai % 16) + (bi % 16)) >= 16;
            o[0] = ((ai % 256) + (bi % 256)) >= 256;
         end
      endcase
      return {q, o};
   endfunction

   // Reference transaction tracker (one op in flight; age counts edges since accept)
   logic        armed = 1'b0;
   logic        m_busy = 1'b0;
   int          m_age = 0;
   logic [1:0]  m_op = 2'b00;
   logic [15:0] m_a = 16'h0000;
   logic [15:0] m_b = 16'h0000;
   logic [7:0]  m_f = 8'h00;
   logic [15:0] m_q = 16'h0000;
   logic [7:0]  m_fl = 8'h00;

   always @(posedge clk) begin
      if (reset) begin
         m_busy <= 1'b0; m_age <= 0; armed <= 1'b1;
      end else if (m_busy) begin
         if (m_age >= 3) begin
            if (rsp_ready) begin m_busy <= 1'b0; m_age <= 0; end
         end else begin
            m_age <= m_age + 1;
         end
      end else if (req_valid) begin
         m_busy <= 1'b1; m_age <= 1;
         m_op <= req_op; m_a <= req_a; m_b <= req_b; m_f <= req_f;
         {m_q, m_fl} <= ref16(req_op, req_a, req_b, req_f);
      end
   end

   // Per-cycle compare of all DUT outputs against the tracker
   always @(negedge clk) begin
      if (armed) begin
         chk("req_ready", 32'(req_ready), 32'(!m_busy));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 3));
         if (m_busy && m_age >= 3) begin
            chk("rsp_q", 32'(rsp_q), 32'(m_q));
            chk("rsp_f", 32'(rsp_f), 32'(m_fl));
         end
         if (m_busy && m_age == 1) begin
            chk("lo_drive", 32'({alu_op, alu_busa, alu_busb, alu_f_in, alu_arith16, alu_z16}),
                32'({(m_op == 2'b01) ? 4'h1 : (m_op == 2'b10) ? 4'h3 : 4'h0,
                     m_a[7:0], m_b[7:0], m_f, (m_op == 2'b00), 1'b0}));
         end else if (m_busy && m_age == 2) begin
            chk("hi_drive", 32'({alu_op, alu_busa, alu_busb, alu_arith16, alu_z16}),
                32'({(m_op == 2'b10) ? 4'h3 : 4'h1, m_a[15:8],
                     (m_op == 2'b11) ? {8{m_b[7]}} : m_b[15:8],
                     (m_op == 2'b00), (m_op == 2'b01 || m_op == 2'b10)}));
         end else begin
            chk("idle_drive", 32'({alu_op, alu_busa, alu_busb, alu_f_in, alu_arith16, alu_z16}),
                32'({4'hF, 26'h0}));
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic [7:0] f);
      bit ok;
      ok = 1'b0;
      req_op = op; req_a = a; req_b = b; req_f = f; req_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (m_busy) begin ok = 1'b1; break; end
      end
      if (!ok) chk("accept_timeout", 32'(0), 32'(1));
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (rsp_valid) begin n = i; break; end
      end
      chk("latency", 32'(n), 32'(3));
   endtask

   task automatic release_rsp();
      #1 rsp_ready = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1 rsp_ready = 1'b0;
   endtask

   task automatic run_lit(input string name, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] f, input logic [15:0] eq, input logic [7:0] ef);
      int n;
      chk({name, "_model"}, 32'(ref16(op, a, b, f)), 32'({eq, ef}));
      issue(op, a, b, f);
      wait_rsp(n);
      chk({name, "_q"}, 32'(rsp_q), 32'(eq));
      chk({name, "_f"}, 32'(rsp_f), 32'(ef));
      release_rsp();
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_rsp_q", 32'(rsp_q), 32'(0));
      chk("reset_rsp_f", 32'(rsp_f), 32'(0));
      chk("reset_alu_op", 32'(alu_op), 32'(4'hF));
      chk("reset_req_ready", 32'(req_ready), 32'(1));

      run_lit("add16", 2'b00, 16'h0FFF, 16'h0001, 8'hC4, 16'h1000, 8'hD4);
      run_lit("adc16", 2'b01, 16'hFFFF, 16'h0000, 8'h01, 16'h0000, 8'h51);
      run_lit("sbc16", 2'b10, 16'h1000, 16'h0001, 8'h00, 16'h0FFF, 8'h1A);
      run_lit("addsp_pos", 2'b11, 16'hFFF8, 16'h0008, 8'h00, 16'h0000, 8'h11);
      run_lit("addsp_neg", 2'b11, 16'h0010, 16'h00F8, 8'h00, 16'h0008, 8'h01);

      // Backpressure with a second request waiting
      issue(2'b00, 16'h1234, 16'h4321, 8'h00);
      wait_rsp(n);
      req_op = 2'b01; req_a = 16'hAAAA; req_b = 16'h5555; req_f = 8'h01; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_req_ready", 32'(req_ready), 32'(0));
         chk("bp_rsp_q", 32'(rsp_q), 32'(16'h5555));
      end
      #1 rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      chk("bp_idle_ready", 32'(req_ready), 32'(1));
      chk("bp_idle_valid", 32'(rsp_valid), 32'(0));
      @(posedge clk); #1 req_valid = 1'b0;
      chk("bp_second_accept", 32'(req_ready), 32'(0));
      wait_rsp(n);
      chk("bp_second_q", 32'(rsp_q), 32'(16'h0000));
      chk("bp_second_f", 32'(rsp_f), 32'(8'h51));
      release_rsp();

      // Reset during the high pass, with a request presented alongside it
      issue(2'b00, 16'h00FF, 16'h0001, 8'h00);
      @(posedge clk); #1;
      reset = 1'b1; req_valid = 1'b1; req_a = 16'h1111; req_b = 16'h2222;
      @(posedge clk); #1;
      reset = 1'b0; req_valid = 1'b0;
      chk("rst_hi_valid", 32'(rsp_valid), 32'(0));
      chk("rst_hi_ready", 32'(req_ready), 32'(1));
      chk("rst_hi_alu_op", 32'(alu_op), 32'(4'hF));
      chk("rst_hi_rsp_q", 32'(rsp_q), 32'(0));
      @(posedge clk); #1;
      chk("rst_req_dropped", 32'(req_ready), 32'(1));
      run_lit("add16_after_rst", 2'b00, 16'h00FF, 16'h0001, 8'h00, 16'h0100, 8'h00);

      // Randomized ops with random idle gaps, hold-off and junk requests while busy
      for (int t = 0; t < 60; t++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         issue(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 8'($urandom));
         req_valid = 1'($urandom_range(0, 1));
         req_a = 16'($urandom); req_b = 16'($urandom); req_op = 2'($urandom);
         wait_rsp(n);
         repeat ($urandom_range(0, 3)) begin
            #1 req_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         release_rsp();
      end

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
